// File: rtl/apbuart_master_arb.sv
// Two-requester APB master for the shared UART slave: round-robin grant, SETUP/ACCESS
// sequencing, PREADY wait with an optional wait-state timeout, per-requester completion.
module apbuart_master_arb #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_done,
    output logic [DATA_W-1:0] req0_rdata,
    output logic              req0_err,
    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_done,
    output logic [DATA_W-1:0] req1_rdata,
    output logic              req1_err,
    output logic              PSELx,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR,
    output logic              busy
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t              state_r, state_nxt_s;
    logic                psel_r, psel_nxt_s;
    logic                penable_r, penable_nxt_s;
    logic                pwrite_r, pwrite_nxt_s;
    logic [ADDR_W-1:0]   paddr_r, paddr_nxt_s;
    logic [DATA_W-1:0]   pwdata_r, pwdata_nxt_s;
    logic                done0_r, done0_nxt_s, done1_r, done1_nxt_s;
    logic                err0_r, err0_nxt_s, err1_r, err1_nxt_s;
    logic [DATA_W-1:0]   rdata0_r, rdata0_nxt_s, rdata1_r, rdata1_nxt_s;
    logic                busy_r;
    logic                owner_r, owner_nxt_s;
    logic                last_grant_r, last_grant_nxt_s;
    logic [CNT_W-1:0]    cnt_r, cnt_nxt_s;
    logic                grant1_s;
    logic                fin_s, fin_err_s;
    logic [DATA_W-1:0]   fin_rdata_s;

    // Next-state and next-output decode; completion results are routed to the owner afterwards
    always_comb begin
        state_nxt_s      = state_r;
        psel_nxt_s       = psel_r;
        penable_nxt_s    = penable_r;
        pwrite_nxt_s     = pwrite_r;
        paddr_nxt_s      = paddr_r;
        pwdata_nxt_s     = pwdata_r;
        owner_nxt_s      = owner_r;
        last_grant_nxt_s = last_grant_r;
        cnt_nxt_s        = cnt_r;
        done0_nxt_s      = 1'b0;
        done1_nxt_s      = 1'b0;
        err0_nxt_s       = 1'b0;
        err1_nxt_s       = 1'b0;
        rdata0_nxt_s     = {DATA_W{1'b0}};
        rdata1_nxt_s     = {DATA_W{1'b0}};
        fin_s            = 1'b0;
        fin_err_s        = 1'b0;
        fin_rdata_s      = {DATA_W{1'b0}};
        // Requester 1 wins when alone, or when both ask and requester 0 was served last
        grant1_s         = req1_valid && (!req0_valid || (last_grant_r == 1'b0));

        case (state_r)
            ST_IDLE: begin
                if (req0_valid || req1_valid) begin
                    owner_nxt_s      = grant1_s;
                    last_grant_nxt_s = grant1_s;
                    pwrite_nxt_s     = grant1_s ? req1_write : req0_write;
                    paddr_nxt_s      = grant1_s ? req1_addr  : req0_addr;
                    pwdata_nxt_s     = grant1_s ? req1_wdata : req0_wdata;
                    psel_nxt_s       = 1'b1;
                    penable_nxt_s    = 1'b0;
                    cnt_nxt_s        = {CNT_W{1'b0}};
                    state_nxt_s      = ST_SETUP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                penable_nxt_s = 1'b1;
                cnt_nxt_s     = {CNT_W{1'b0}};
                state_nxt_s   = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (PREADY) begin
                    fin_s         = 1'b1;
                    fin_err_s     = PSLVERR;
                    fin_rdata_s   = pwrite_r ? {DATA_W{1'b0}} : PRDATA;
                    psel_nxt_s    = 1'b0;
                    penable_nxt_s = 1'b0;
                    state_nxt_s   = ST_DONE;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_r == CNT_LAST)) begin
                    fin_s         = 1'b1;
                    fin_err_s     = 1'b1;
                    psel_nxt_s    = 1'b0;
                    penable_nxt_s = 1'b0;
                    state_nxt_s   = ST_DONE;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                psel_nxt_s    = 1'b0;
                penable_nxt_s = 1'b0;
                state_nxt_s   = ST_IDLE;
            end
        endcase

        if (fin_s) begin
            if (owner_r) begin
                done1_nxt_s  = 1'b1;
                err1_nxt_s   = fin_err_s;
                rdata1_nxt_s = fin_rdata_s;
            end else begin
                done0_nxt_s  = 1'b1;
                err0_nxt_s   = fin_err_s;
                rdata0_nxt_s = fin_rdata_s;
            end
        end else begin
            cnt_nxt_s = cnt_nxt_s;
        end
    end

    // State, bus and completion registers with synchronous reset
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_r      <= ST_IDLE;
            psel_r       <= 1'b0;
            penable_r    <= 1'b0;
            pwrite_r     <= 1'b0;
            paddr_r      <= {ADDR_W{1'b0}};
            pwdata_r     <= {DATA_W{1'b0}};
            done0_r      <= 1'b0;
            done1_r      <= 1'b0;
            err0_r       <= 1'b0;
            err1_r       <= 1'b0;
            rdata0_r     <= {DATA_W{1'b0}};
            rdata1_r     <= {DATA_W{1'b0}};
            busy_r       <= 1'b0;
            owner_r      <= 1'b0;
            last_grant_r <= 1'b1;
            cnt_r        <= {CNT_W{1'b0}};
        end else begin
            state_r      <= state_nxt_s;
            psel_r       <= psel_nxt_s;
            penable_r    <= penable_nxt_s;
            pwrite_r     <= pwrite_nxt_s;
            paddr_r      <= paddr_nxt_s;
            pwdata_r     <= pwdata_nxt_s;
            done0_r      <= done0_nxt_s;
            done1_r      <= done1_nxt_s;
            err0_r       <= err0_nxt_s;
            err1_r       <= err1_nxt_s;
            rdata0_r     <= rdata0_nxt_s;
            rdata1_r     <= rdata1_nxt_s;
            busy_r       <= (state_nxt_s != ST_IDLE);
            owner_r      <= owner_nxt_s;
            last_grant_r <= last_grant_nxt_s;
            cnt_r        <= cnt_nxt_s;
        end
    end

    assign PSELx      = psel_r;
    assign PENABLE    = penable_r;
    assign PWRITE     = pwrite_r;
    assign PADDR      = paddr_r;
    assign PWDATA     = pwdata_r;
    assign req0_done  = done0_r;
    assign req0_rdata = rdata0_r;
    assign req0_err   = err0_r;
    assign req1_done  = done1_r;
    assign req1_rdata = rdata1_r;
    assign req1_err   = err1_r;
    assign busy       = busy_r;

endmodule

// File: doc/apbuart_master_arb.md
Name: apbuart_master_arb

Overview:
- APB master controller that shares the single APB UART slave between two on-chip requesters (requester 0 and requester 1).
- Arbitrates with round-robin priority and sequences the APB SETUP/ACCESS phases.
- Waits on PREADY, bounded by a timeout, and returns read data and error status to the granted requester.
- Sits between the requesters and the UART slave's APB port (PSELx/PENABLE/PWRITE/PADDR/PWDATA/PRDATA/PREADY/PSLVERR).

Parameters:
- ADDR_W, 32, APB address width.
- DATA_W, 32, APB data width.
- TIMEOUT_CYCLES, 16, ACCESS-phase wait-state limit; 0 disables the timeout.

Ports:
- PCLK  in  1  clock.
- PRESET  in  1  synchronous active-high reset.
- req0_valid  in  1  requester 0 transfer request; held until req0_done.
- req0_write  in  1  1 = write, 0 = read.
- req0_addr  in  ADDR_W  address.
- req0_wdata  in  DATA_W  write data.
- req0_done  out  1  one-cycle completion pulse.
- req0_rdata  out  DATA_W  read data, valid with req0_done.
- req0_err  out  1  slave error or timeout, valid with req0_done.
- req1_*  same set as req0_* for requester 1.
- PSELx  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  ADDR_W  APB address.
- PWDATA  out  DATA_W  APB write data.
- PRDATA  in  DATA_W  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB slave error.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- All outputs are registered.
- Reset (PRESET sampled high at a PCLK edge):
  - State goes to IDLE; all outputs are 0 after that edge; last_grant=1, so requester 0 wins the first contention.
  - The timeout counter clears.
  - Reset during SETUP or ACCESS aborts the transfer with no done pulse.
- FSM states: IDLE, SETUP, ACCESS, DONE.
- IDLE:
  - If any reqN_valid, grant and latch addr/write/wdata into PADDR/PWRITE/PWDATA, set PSELx=1, and go to SETUP.
  - Otherwise stay in IDLE.
- Arbitration:
  - Only one valid: that requester wins.
  - Both valid: the requester not equal to last_grant wins.
  - last_grant updates on grant.
- SETUP: PSELx=1, PENABLE=0; unconditionally go to ACCESS and set PENABLE=1.
- ACCESS, PSELx=1 and PENABLE=1, with the cycle counter incrementing each cycle that PREADY=0:
  - PREADY=1: capture PRDATA (reads only; writes return rdata=0) and PSLVERR into rdata/err. Drive PSELx=0, PENABLE=0, pulse the owner's reqN_done for one cycle, and go to DONE.
  - PREADY=0 with TIMEOUT_CYCLES≠0 and counter==TIMEOUT_CYCLES-1: abort. Drive PSELx=0, PENABLE=0, done=1, err=1, rdata=0, and go to DONE.
  - PREADY has priority over timeout in the same cycle.
- DONE: one-cycle guard in which requests are ignored, so the requester can drop valid; then go to IDLE. reqN_done, rdata and err clear to 0 here.
- Latency with zero wait states:
  - Request seen in IDLE in cycle 0 → PSELx=1 in cycle 1, PENABLE=1 in cycle 2, done in cycle 3.
  - Next grant is possible in cycle 4, giving throughput of one transfer per 4 cycles.
  - Each PREADY wait state adds one cycle.
- Address and control are stable on the APB bus from SETUP through ACCESS.
- reqN_valid dropping mid-transfer is illegal. The transfer still completes and done still pulses.
- The non-owner's done, rdata and err remain 0.

Test Plan:
- Write, zero wait states: req0 write addr 0x0000_0004, wdata 0x0000_00A5, PREADY=1 → PSELx in cycle 1, PENABLE in cycle 2, PWDATA=0xA5, req0_done in cycle 3 with err=0 and rdata=0.
- Read, 3 wait states: req1 read addr 0x0000_0008, PREADY low 3 cycles then high with PRDATA=0x0000_005A → req1_done in cycle 6 with rdata=0x5A, err=0, req0_done=0.
- Simultaneous requests from reset: req0 and req1 valid together → req0 served first, req1 granted in cycle 4 (its done in cycle 7). Repeat both valid → order alternates 0,1,0,1.
- Slave error: PREADY=1 with PSLVERR=1 → reqN_err=1 with done. Next transfer returns err=0.
- Timeout: TIMEOUT_CYCLES=16, PREADY held 0 → done with err=1 and rdata=0 after 16 ACCESS cycles, PSELx/PENABLE drop the same edge. Also PREADY rising exactly on cycle 16 → normal completion, err=PSLVERR.
- Reset mid-ACCESS: PRESET high one cycle during wait states → next cycle all outputs 0, no done pulse, state IDLE. The next contention grants req0 first.
